// File: rtl/pe_inject_arbiter_pkg.sv
// Shared constants and helpers for the PE injection arbiter: packet header field
// extraction, a constant clog2 and the drop counter width.
package pe_inject_arbiter_pkg;

  localparam int unsigned DropCntWidth = 8;
  localparam logic [DropCntWidth-1:0] DropCntMax = '1;

  // Ceiling log2; returns at least 1 so index buses never collapse to zero width.
  function automatic int unsigned clog2(input int unsigned value);
    int unsigned result;
    result = 1;
    for (int unsigned i = 1; i < 32; i++) begin
      if ((32'd1 << i) < value) begin
        result = i + 1;
      end
    end
    return result;
  endfunction

  function automatic int unsigned hdr_width(input int unsigned x_size, input int unsigned y_size);
    return x_size + y_size;
  endfunction

  function automatic int unsigned dest_x_lsb();
    return 0;
  endfunction

  function automatic int unsigned dest_y_lsb(input int unsigned x_size);
    return x_size;
  endfunction

  function automatic logic [31:0] field_get(input logic [63:0]   hdr,
                                            input int unsigned   lsb,
                                            input int unsigned   width);
    logic [63:0] mask;
    mask = (64'd1 << width) - 64'd1;
    return 32'((hdr >> lsb) & mask);
  endfunction

endpackage

// File: rtl/pe_inject_arbiter_rr_arbiter.sv
// N-way round-robin arbiter: one-hot grant plus encoded index, with the priority
// pointer moving just past the winner whenever the caller reports an accept.
module pe_inject_arbiter_rr_arbiter #(
  parameter int unsigned N    = 4,
  parameter int unsigned IdxW = 2
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic [N-1:0]    req_i,
  input  logic            accept_i,
  output logic [N-1:0]    gnt_o,
  output logic [IdxW-1:0] gnt_idx_o,
  output logic            gnt_valid_o
);

  localparam logic [IdxW:0]   NumReq  = (IdxW + 1)'(N);
  localparam logic [IdxW-1:0] LastIdx = IdxW'(N - 1);

  logic [IdxW-1:0] ptr_q, ptr_d;
  logic [IdxW:0]   cand;
  logic            found;

  // Scan from the pointer upward with wrap; first asserted request wins.
  always_comb begin
    gnt_o       = '0;
    gnt_idx_o   = '0;
    gnt_valid_o = 1'b0;
    found       = 1'b0;
    cand        = '0;
    for (int unsigned off = 0; off < N; off++) begin
      cand = {1'b0, ptr_q} + (IdxW + 1)'(off);
      if (cand >= NumReq) begin
        cand = cand - NumReq;
      end
      if (!found && req_i[cand[IdxW-1:0]]) begin
        found                     = 1'b1;
        gnt_idx_o                 = cand[IdxW-1:0];
        gnt_o[cand[IdxW-1:0]]     = 1'b1;
        gnt_valid_o               = 1'b1;
      end
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (accept_i && gnt_valid_o) begin
      ptr_d = (gnt_idx_o == LastIdx) ? '0 : gnt_idx_o + IdxW'(1);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/pe_inject_arbiter.sv
// Shares a mesh tile's PE injection port among N_REQ local requesters through a
// round-robin arbiter and a 2-entry output FIFO; out-of-mesh packets are dropped.
module pe_inject_arbiter
  import pe_inject_arbiter_pkg::*;
#(
  parameter int unsigned N_REQ       = 4,
  parameter int unsigned X           = 2,
  parameter int unsigned Y           = 2,
  parameter int unsigned data_width  = 32,
  parameter int unsigned x_size      = 1,
  parameter int unsigned y_size      = 1,
  parameter int unsigned total_width = x_size + y_size + data_width,
  parameter int unsigned STALL_LIMIT = 64
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [N_REQ-1:0]             req_valid,
  input  logic [N_REQ*total_width-1:0] req_data,
  output logic [N_REQ-1:0]             req_ready,
  output logic                         o_valid_pe,
  output logic [total_width-1:0]       o_data_pe,
  input  logic                         i_ready_pe,
  output logic [clog2(N_REQ)-1:0]      grant_id,
  output logic [DropCntWidth-1:0]      drop_cnt,
  output logic                         stall
);

  localparam int unsigned IdxW   = clog2(N_REQ);
  localparam int unsigned HdrW   = hdr_width(x_size, y_size);
  localparam int unsigned StallW = clog2(STALL_LIMIT + 1);
  localparam logic [StallW-1:0] StallMax = StallW'(STALL_LIMIT);

  logic [N_REQ-1:0]       gnt;
  logic [IdxW-1:0]        gnt_idx;
  logic                   gnt_valid;
  logic [total_width-1:0] win_pkt;
  logic [63:0]            win_hdr;
  logic [31:0]            dest_x, dest_y;
  logic                   win_oor;
  logic                   accept, push, pop;

  logic [total_width-1:0] mem_q [2];
  logic                   rd_ptr_q, rd_ptr_d;
  logic                   wr_ptr;
  logic [1:0]             count_q, count_d;
  logic [DropCntWidth-1:0] drop_q, drop_d;
  logic [StallW-1:0]      stall_cnt_q, stall_cnt_d;

  pe_inject_arbiter_rr_arbiter #(
    .N    (N_REQ),
    .IdxW (IdxW)
  ) u_rr_arbiter (
    .clk_i       (clk),
    .rst_i       (rst),
    .req_i       (req_valid),
    .accept_i    (accept),
    .gnt_o       (gnt),
    .gnt_idx_o   (gnt_idx),
    .gnt_valid_o (gnt_valid)
  );

  always_comb begin
    win_pkt = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (gnt[i]) begin
        win_pkt = req_data[i*total_width +: total_width];
      end
    end
  end

  assign win_hdr = 64'(win_pkt[HdrW-1:0]);
  assign dest_x  = field_get(win_hdr, dest_x_lsb(), x_size);
  assign dest_y  = field_get(win_hdr, dest_y_lsb(x_size), y_size);
  assign win_oor = (dest_x >= X) || (dest_y >= Y);

  // Drops bypass the FIFO, so they are accepted even when it is full. Nothing here
  // looks at i_ready_pe, keeping the switch off the requester ready path.
  assign accept    = gnt_valid && ((count_q != 2'd2) || win_oor);
  assign push      = accept && !win_oor;
  assign pop       = o_valid_pe && i_ready_pe;
  assign req_ready = accept ? gnt : '0;
  assign grant_id  = gnt_idx;

  assign wr_ptr   = rd_ptr_q ^ count_q[0];
  assign rd_ptr_d = rd_ptr_q ^ pop;

  always_comb begin
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
  end

  always_comb begin
    drop_d = drop_q;
    if (accept && win_oor && (drop_q != DropCntMax)) begin
      drop_d = drop_q + DropCntWidth'(1);
    end
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (!o_valid_pe || pop) begin
      stall_cnt_d = '0;
    end else if (stall_cnt_q != StallMax) begin
      stall_cnt_d = stall_cnt_q + StallW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_q[0]    <= '0;
      mem_q[1]    <= '0;
      rd_ptr_q    <= 1'b0;
      count_q     <= '0;
      drop_q      <= '0;
      stall_cnt_q <= '0;
    end else begin
      if (push) begin
        mem_q[wr_ptr] <= win_pkt;
      end
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      drop_q      <= drop_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  // Empty FIFO presents zero data so an idle port looks exactly like reset.
  assign o_valid_pe = (count_q != 2'd0);
  assign o_data_pe  = o_valid_pe ? mem_q[rd_ptr_q] : '0;
  assign drop_cnt   = drop_q;
  assign stall      = (stall_cnt_q == StallMax);

endmodule

// File: tb/tb_pe_inject_arbiter.sv
// Randomized bench for pe_inject_arbiter against a queue-based reference model of
// round-robin choice, FIFO contents, drop count and blocked-head duration.
module tb_pe_inject_arbiter;

  localparam int NReq = 4;
  localparam int Xm   = 2;
  localparam int Ym   = 2;
  localparam int Dw   = 32;
  localparam int Xs   = 2;
  localparam int Ys   = 2;
  localparam int Tw   = Xs + Ys + Dw;
  localparam int Lim  = 64;
  localparam int Iw   = 2;

  logic                 clk = 1'b0;
  logic                 rst;
  logic [NReq-1:0]      req_valid;
  logic [NReq*Tw-1:0]   req_data;
  logic [NReq-1:0]      req_ready;
  logic                 o_valid_pe;
  logic [Tw-1:0]        o_data_pe;
  logic                 i_ready_pe;
  logic [Iw-1:0]        grant_id;
  logic [7:0]           drop_cnt;
  logic                 stall;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  pe_inject_arbiter #(
    .N_REQ       (NReq),
    .X           (Xm),
    .Y           (Ym),
    .data_width  (Dw),
    .x_size      (Xs),
    .y_size      (Ys),
    .total_width (Tw),
    .STALL_LIMIT (Lim)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_data   (req_data),
    .req_ready  (req_ready),
    .o_valid_pe (o_valid_pe),
    .o_data_pe  (o_data_pe),
    .i_ready_pe (i_ready_pe),
    .grant_id   (grant_id),
    .drop_cnt   (drop_cnt),
    .stall      (stall)
  );

  // Reference model state
  int            m_ptr;
  logic [Tw-1:0] m_q[$];
  int            m_drops;
  int            m_blocked;
  logic [Tw-1:0] pkts [NReq];
  logic [NReq-1:0] exp_ready;
  int            exp_gid;
  bit            exp_acc;
  bit            exp_oor;

  function automatic logic [Tw-1:0] mk_pkt(input int x, input int y, input logic [Dw-1:0] d);
    logic [Tw-1:0] p;
    p = {d, Ys'(y), Xs'(x)};
    return p;
  endfunction

  function automatic logic [Tw-1:0] rand_pkt(input bit allow_oor);
    int x;
    int y;
    x = $urandom_range(0, 1);
    y = $urandom_range(0, 1);
    if (allow_oor && $urandom_range(0, 3) == 0) begin
      if ($urandom_range(0, 1) == 1) x = $urandom_range(2, 3);
      else y = $urandom_range(2, 3);
    end
    return mk_pkt(x, y, $urandom);
  endfunction

  function automatic bit exp_valid();
    return m_q.size() != 0;
  endfunction

  function automatic logic [Tw-1:0] exp_data();
    if (m_q.size() == 0) return '0;
    return m_q[0];
  endfunction

  function automatic logic [7:0] exp_drop();
    return (m_drops > 255) ? 8'd255 : 8'(m_drops);
  endfunction

  function automatic bit exp_stall();
    return m_blocked >= Lim;
  endfunction

  task automatic present();
    for (int i = 0; i < NReq; i++) req_data[i*Tw +: Tw] = pkts[i];
  endtask

  task automatic model_reset();
    m_ptr = 0;
    m_q.delete();
    m_drops = 0;
    m_blocked = 0;
  endtask

  task automatic model_eval();
    int i;
    exp_ready = '0;
    exp_gid = -1;
    exp_acc = 0;
    exp_oor = 0;
    for (int k = 0; k < NReq; k++) begin
      i = (m_ptr + k) % NReq;
      if (exp_gid < 0 && req_valid[i]) begin
        exp_gid = i;
        exp_oor = (int'(pkts[i][Xs-1:0]) >= Xm) || (int'(pkts[i][Xs+Ys-1:Xs]) >= Ym);
        exp_acc = exp_oor || (m_q.size() < 2);
      end
    end
    if (exp_acc) exp_ready[exp_gid] = 1'b1;
  endtask

  task automatic model_commit();
    bit had_head;
    had_head = m_q.size() != 0;
    if (had_head && !i_ready_pe) m_blocked++;
    else m_blocked = 0;
    if (had_head && i_ready_pe) void'(m_q.pop_front());
    if (exp_acc) begin
      m_ptr = (exp_gid + 1) % NReq;
      if (exp_oor) m_drops++;
      else m_q.push_back(pkts[exp_gid]);
    end
  endtask

  task automatic settle();
    #1;
    model_eval();
  endtask

  task automatic advance();
    @(posedge clk);
    model_commit();
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req_valid = '0;
    i_ready_pe = 1'b0;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    req_valid = '0;
    i_ready_pe = 1'b0;
    for (int i = 0; i < NReq; i++) pkts[i] = '0;
    present();
    model_reset();
    @(negedge clk);
    @(negedge clk);
    #1;
    checks++;
    if (o_valid_pe !== 1'b0 || o_data_pe !== '0) begin
      failures++;
      $display("FAIL reset_out got v=%0b d=%0h exp v=0 d=0", o_valid_pe, o_data_pe);
    end
    checks++;
    if (drop_cnt !== 8'd0 || stall !== 1'b0 || req_ready !== '0) begin
      failures++;
      $display("FAIL reset_cnt got drop=%0d stall=%0b rdy=%0b exp 0 0 0", drop_cnt, stall, req_ready);
    end
    rst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      i_ready_pe = k[0];
      #1;
      checks++;
      if (o_valid_pe !== 1'b0 || o_data_pe !== '0 || stall !== 1'b0 || drop_cnt !== 8'd0) begin
        failures++;
        $display("FAIL idle got v=%0b d=%0h stall=%0b drop=%0d exp all 0", o_valid_pe, o_data_pe,
                 stall, drop_cnt);
      end
    end
    @(negedge clk);
  endtask

  task automatic test_fairness();
    do_reset();
    i_ready_pe = 1'b1;
    for (int i = 0; i < NReq; i++) pkts[i] = mk_pkt(1, 1, $urandom);
    req_valid = '1;
    present();
    for (int k = 0; k < 12; k++) begin
      settle();
      checks++;
      if (grant_id !== Iw'(k % NReq) || req_ready !== NReq'(1 << (k % NReq))) begin
        failures++;
        $display("FAIL fair_grant cyc=%0d got id=%0d rdy=%b exp id=%0d", k, grant_id, req_ready,
                 k % NReq);
      end
      checks++;
      if (o_valid_pe !== exp_valid() || o_data_pe !== exp_data()) begin
        failures++;
        $display("FAIL fair_out cyc=%0d got v=%0b d=%0h exp v=%0b d=%0h", k, o_valid_pe, o_data_pe,
                 exp_valid(), exp_data());
      end
      if (k >= 1) begin
        checks++;
        if (o_valid_pe !== 1'b1) begin
          failures++;
          $display("FAIL fair_continuous cyc=%0d got v=%0b exp v=1", k, o_valid_pe);
        end
      end
      advance();
      if (exp_acc) pkts[exp_gid] = mk_pkt(1, 1, $urandom);
      present();
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    i_ready_pe = 1'b0;
    for (int i = 0; i < NReq; i++) pkts[i] = rand_pkt(1'b0);
    req_valid = '1;
    present();
    for (int k = 0; k < 12; k++) begin
      settle();
      checks++;
      if (req_ready !== exp_ready || (k >= 2 && req_ready !== '0)) begin
        failures++;
        $display("FAIL bp_ready cyc=%0d got %b exp %b", k, req_ready, exp_ready);
      end
      checks++;
      if (o_valid_pe !== exp_valid() || o_data_pe !== exp_data()) begin
        failures++;
        $display("FAIL bp_head cyc=%0d got v=%0b d=%0h exp v=%0b d=%0h", k, o_valid_pe, o_data_pe,
                 exp_valid(), exp_data());
      end
      advance();
      if (exp_acc) pkts[exp_gid] = rand_pkt(1'b0);
      present();
    end
    i_ready_pe = 1'b1;
    for (int k = 0; k < 8; k++) begin
      settle();
      checks++;
      if (req_ready !== exp_ready || o_valid_pe !== exp_valid() || o_data_pe !== exp_data()) begin
        failures++;
        $display("FAIL bp_release cyc=%0d got rdy=%b d=%0h exp rdy=%b d=%0h", k, req_ready,
                 o_data_pe, exp_ready, exp_data());
      end
      advance();
      if (exp_acc) pkts[exp_gid] = rand_pkt(1'b0);
      present();
    end
  endtask

  task automatic test_drop();
    do_reset();
    i_ready_pe = 1'b0;
    req_valid = 4'b0001;
    pkts[0] = rand_pkt(1'b0);
    present();
    for (int k = 0; k < 2; k++) begin
      settle();
      advance();
      pkts[0] = rand_pkt(1'b0);
      present();
    end
    req_valid = 4'b0100;
    pkts[2] = mk_pkt(2, 0, $urandom);
    present();
    for (int k = 0; k < 300; k++) begin
      settle();
      checks++;
      if (req_ready !== 4'b0100 || req_ready !== exp_ready) begin
        failures++;
        $display("FAIL drop_ready cyc=%0d got %b exp 0100", k, req_ready);
      end
      checks++;
      if (drop_cnt !== exp_drop() || (k == 1 && drop_cnt !== 8'd1)) begin
        failures++;
        $display("FAIL drop_cnt cyc=%0d got %0d exp %0d", k, drop_cnt, exp_drop());
      end
      checks++;
      if (o_data_pe !== exp_data() || o_valid_pe !== 1'b1) begin
        failures++;
        $display("FAIL drop_head cyc=%0d got d=%0h exp d=%0h", k, o_data_pe, exp_data());
      end
      advance();
      pkts[2] = mk_pkt($urandom_range(2, 3), $urandom_range(0, 3), $urandom);
      present();
    end
    settle();
    checks++;
    if (drop_cnt !== 8'd255) begin
      failures++;
      $display("FAIL drop_sat got %0d exp 255", drop_cnt);
    end
  endtask

  task automatic test_stall();
    do_reset();
    i_ready_pe = 1'b0;
    req_valid = 4'b1000;
    pkts[3] = rand_pkt(1'b0);
    present();
    settle();
    advance();
    req_valid = '0;
    for (int k = 0; k < 70; k++) begin
      settle();
      checks++;
      if (stall !== exp_stall() || (k == 63 && stall !== 1'b0) || (k == 64 && stall !== 1'b1)) begin
        failures++;
        $display("FAIL stall_rise cyc=%0d got %0b exp %0b", k, stall, exp_stall());
      end
      advance();
    end
    i_ready_pe = 1'b1;
    settle();
    checks++;
    if (stall !== 1'b1 || o_data_pe !== exp_data()) begin
      failures++;
      $display("FAIL stall_hold got stall=%0b d=%0h exp stall=1 d=%0h", stall, o_data_pe, exp_data());
    end
    advance();
    i_ready_pe = 1'b0;
    settle();
    checks++;
    if (stall !== 1'b0 || o_valid_pe !== 1'b0) begin
      failures++;
      $display("FAIL stall_clear got stall=%0b v=%0b exp 0 0", stall, o_valid_pe);
    end
  endtask

  task automatic test_push_pop();
    do_reset();
    i_ready_pe = 1'b1;
    req_valid = 4'b0010;
    pkts[1] = rand_pkt(1'b0);
    present();
    for (int k = 0; k < 21; k++) begin
      settle();
      checks++;
      if (req_ready !== 4'b0010 || o_valid_pe !== exp_valid() || o_data_pe !== exp_data()) begin
        failures++;
        $display("FAIL pushpop cyc=%0d got rdy=%b v=%0b d=%0h exp rdy=0010 v=%0b d=%0h", k,
                 req_ready, o_valid_pe, o_data_pe, exp_valid(), exp_data());
      end
      advance();
      if (exp_acc) pkts[1] = rand_pkt(1'b0);
      present();
    end
  endtask

  task automatic test_random(input int cycles);
    for (int k = 0; k < cycles; k++) begin
      req_valid = NReq'($urandom);
      i_ready_pe = ($urandom_range(0, 3) != 0);
      for (int i = 0; i < NReq; i++) pkts[i] = rand_pkt(1'b1);
      present();
      settle();
      checks++;
      if (req_ready !== exp_ready || (exp_acc && grant_id !== Iw'(exp_gid))) begin
        failures++;
        $display("FAIL rand_arb cyc=%0d got rdy=%b id=%0d exp rdy=%b id=%0d", k, req_ready,
                 grant_id, exp_ready, exp_gid);
      end
      checks++;
      if (o_valid_pe !== exp_valid() || o_data_pe !== exp_data()) begin
        failures++;
        $display("FAIL rand_out cyc=%0d got v=%0b d=%0h exp v=%0b d=%0h", k, o_valid_pe, o_data_pe,
                 exp_valid(), exp_data());
      end
      checks++;
      if (drop_cnt !== exp_drop() || stall !== exp_stall()) begin
        failures++;
        $display("FAIL rand_cnt cyc=%0d got drop=%0d stall=%0b exp drop=%0d stall=%0b", k,
                 drop_cnt, stall, exp_drop(), exp_stall());
      end
      advance();
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    test_random(25);
    #3;
    rst = 1'b1;
    model_reset();
    #1;
    checks++;
    if (o_valid_pe !== 1'b0 || drop_cnt !== 8'd0 || stall !== 1'b0 || o_data_pe !== '0) begin
      failures++;
      $display("FAIL async_rst got v=%0b drop=%0d stall=%0b exp 0 0 0", o_valid_pe, drop_cnt, stall);
    end
    req_valid = '0;
    @(negedge clk);
    #2;
    rst = 1'b0;
    @(negedge clk);
    req_valid = '1;
    for (int i = 0; i < NReq; i++) pkts[i] = rand_pkt(1'b0);
    present();
    settle();
    checks++;
    if (grant_id !== Iw'(0) || req_ready !== 4'b0001) begin
      failures++;
      $display("FAIL async_first_grant got id=%0d rdy=%b exp id=0 rdy=0001", grant_id, req_ready);
    end
    advance();
  endtask

  initial begin
    req_valid = '0;
    req_data = '0;
    i_ready_pe = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    test_reset();
    test_fairness();
    test_backpressure();
    test_drop();
    test_stall();
    test_push_pop();
    do_reset();
    test_random(400);
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pe_inject_arbiter.md
Name: pe_inject_arbiter

Overview:
- Shares the single PE injection port of a mesh switch tile among N_REQ local requesters (cores, DMA, config master).
- Round-robin arbitration feeds a 2-entry output FIFO that drives the switch's PE input. The switch's PE-ready backpressure stalls that FIFO.
- Packets whose destination lies outside the X×Y mesh are acknowledged, dropped and counted, never injected.
- Sits between the tile's local masters and the switch PE port.

Parameters:
- N_REQ, 4, number of requesters (2..8).
- X, 2, mesh width in tiles.
- Y, 2, mesh height in tiles.
- data_width, 32, payload bits.
- x_size, 1, destination-x field width (packet bits [x_size-1:0]).
- y_size, 1, destination-y field width (packet bits [x_size+y_size-1:x_size]).
- total_width, x_size+y_size+data_width, packet width.
- STALL_LIMIT, 64, cycles of blocked head-of-FIFO before the stall flag is raised.

Ports:
- clk  input  1  clock.
- rst  input  1  asynchronous, active-high reset.
- req_valid  input  N_REQ  per-requester packet valid.
- req_data  input  N_REQ*total_width  packets; requester i occupies bits [i*total_width +: total_width].
- req_ready  output  N_REQ  per-requester accept; a transfer occurs when req_valid[i] & req_ready[i].
- o_valid_pe  output  1  packet valid toward the switch PE input.
- o_data_pe  output  total_width  packet toward the switch PE input.
- i_ready_pe  input  1  switch PE-ready; FIFO pops when o_valid_pe & i_ready_pe.
- grant_id  output  clog2(N_REQ)  index of the requester accepted this cycle; only meaningful when any req_ready is high.
- drop_cnt  output  8  saturating count of dropped out-of-range packets.
- stall  output  1  head of FIFO has been blocked for at least STALL_LIMIT cycles.

Behaviour:
- Reset (async assert, sync-safe deassert):
  - FIFO count = 0, o_valid_pe = 0, o_data_pe = 0.
  - rr_ptr = 0, drop_cnt = 0, stall = 0, stall counter = 0.
- Arbitration (combinational):
  - Among asserted req_valid bits, the winner is the first index at or after rr_ptr, modulo N_REQ.
  - req_ready is one-hot on the winner, and only when the FIFO count < 2 or the winner's packet is out of range. All other req_ready bits are 0.
  - req_ready never depends on i_ready_pe, so there is no combinational path from the switch into the requesters.
- Pointer update: on an accepted transfer from winner w, rr_ptr <= (w+1) mod N_REQ. With no transfer, rr_ptr holds.
- Range check: a packet is out of range if its dest x >= X or dest y >= Y.
  - Out-of-range: accepted and not pushed; drop_cnt increments, saturating at 255. The pointer still advances.
  - In-range: pushed into the FIFO.
- FIFO: 2 entries, in order. The head drives o_data_pe; o_valid_pe = (count != 0).
  - Push and pop in the same cycle is legal: count unchanged, data ordering preserved.
  - Push is blocked at count = 2 even if a pop occurs that cycle.
  - Throughput: 1 packet/cycle while i_ready_pe is held high.
- Latency: a packet accepted at edge k into an empty FIFO appears on o_valid_pe/o_data_pe after edge k. This is 1 cycle of latency; there is no combinational bypass.
- Stall watchdog:
  - The counter increments each cycle o_valid_pe & ~i_ready_pe holds, saturating at STALL_LIMIT.
  - stall = (counter == STALL_LIMIT).
  - Any pop, or an empty FIFO, clears both the counter and stall on the next edge.
- Head stability: while o_valid_pe=1 and i_ready_pe=0, o_data_pe must not change.
- Reset mid-operation: FIFO contents are discarded (count forced to 0). A requester handshake in progress is lost; requesters re-present after reset.
- Idle: with no req_valid asserted and the FIFO empty, all outputs stay at their reset values except the counters, which hold.

Decomposition:
- Shared package holds:
  - packet field helpers (dest x/y slice positions derived from x_size/y_size);
  - the clog2 function;
  - the drop counter width constant (8).
- One sub-module is natural: rr_arbiter (N_REQ-wide round-robin, one-hot grant plus encoded index, pointer advance on accept). It is reusable for the switch output-port arbitration.
- The 2-entry FIFO and watchdog remain inline.

Test Plan:
- Fairness: N_REQ=4, all req_valid=1 continuously, i_ready_pe=1, X=Y=2, all dests (1,1) -> grants 0,1,2,3,0,… one per cycle; o_valid_pe continuous from cycle 2; packets out in grant order.
- Backpressure: fill the FIFO, then hold i_ready_pe=0 for 10 cycles -> req_ready all 0, o_data_pe stable, count=2; release -> 2 pops and new accepts resume with no loss or duplication.
- Drop: requester 2 sends dest x=2 with X=2 (x_size=2) -> req_ready[2]=1 even with the FIFO full, nothing injected, drop_cnt 0→1; 300 such packets -> drop_cnt=255.
- Stall: STALL_LIMIT=64, one packet queued, i_ready_pe=0 -> stall rises after 64 blocked cycles; a single i_ready_pe pulse -> stall=0 next cycle.
- Simultaneous push/pop: count=1, i_ready_pe=1, one requester valid -> count stays 1, order preserved over 20 cycles.
- Async reset mid-burst: assert rst between edges during traffic -> o_valid_pe, drop_cnt, stall immediately 0; after release, first grant goes to requester 0.
